// File: rtl/pc_sequencer.sv
// Program-counter controller for the fetch stage: start/run/halt FSM, next-PC select, watchdog.
// Optional build macro PC_SEQ_PERF_EN adds the cyc_cnt/br_cnt performance counters.
//
// state  | meaning
// IDLE   | after reset, pc holds, waiting for start
// RUN    | executing; pc advances on every unstalled cycle
// HALTED | HALT seen or watchdog expired; done=1, waiting for restart
module pc_sequencer #(
    parameter int D       = 12,
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [D-1:0] start_addr,
    input  logic         stall,
    input  logic         halt,
    input  logic         jump,
    input  logic [D-1:0] jump_addr,
    input  logic         br_taken,
    input  logic [2:0]   br_sel,
    output logic [2:0]   lut_sel,
    input  logic [D-1:0] lut_target,
    output logic [D-1:0] pc,
    output logic         busy,
    output logic         done,
`ifdef PC_SEQ_PERF_EN
    output logic [31:0]  cyc_cnt,
    output logic [31:0]  br_cnt,
`endif
    output logic         timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic        WDOG_EN = (TIMEOUT != 0);
    localparam logic [31:0] TO_VAL  = 32'(TIMEOUT);
    localparam logic [D-1:0] PC_ONE = {{(D-1){1'b0}}, 1'b1};

    state_t       state, state_nxt;
    logic [D-1:0] pc_nxt;
    logic [31:0]  count, count_nxt, count_inc;
    logic         timeout_nxt;
    logic         taken;

    assign lut_sel   = br_sel;
    assign count_inc = count + 32'd1;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        count_nxt   = count;
        timeout_nxt = timeout;
        taken       = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_nxt   = RUN;
                    pc_nxt      = start_addr;
                    count_nxt   = '0;
                    timeout_nxt = 1'b0;
                end
            end
            RUN: begin
                if (!stall) begin
                    count_nxt = count_inc;
                    // explicit HALT outranks the watchdog so timeout stays clear
                    if (halt) begin
                        state_nxt = HALTED;
                    end else if (WDOG_EN && count_inc == TO_VAL) begin
                        state_nxt   = HALTED;
                        timeout_nxt = 1'b1;
                    end else if (jump) begin
                        pc_nxt = jump_addr;
                        taken  = 1'b1;
                    end else if (br_taken) begin
                        pc_nxt = pc + lut_target;
                        taken  = 1'b1;
                    end else begin
                        pc_nxt = pc + PC_ONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            count   <= count_nxt;
            busy    <= (state_nxt == RUN);
            done    <= (state_nxt == HALTED);
            timeout <= timeout_nxt;
        end
    end

`ifdef PC_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= '0;
            br_cnt  <= '0;
        end else if (state != RUN) begin
            if (start) begin
                cyc_cnt <= '0;
                br_cnt  <= '0;
            end
        end else begin
            if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
            if (taken && br_cnt != '1) br_cnt <= br_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the program counter.
module tb_pc_sequencer;
    localparam int D  = 12;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset, start, stall, halt, jump, br_taken;
    logic [D-1:0] start_addr, jump_addr, lut_target;
    logic [2:0]   br_sel, lut_sel;
    logic [D-1:0] pc;
    logic         busy, done, timeout;
`ifdef PC_SEQ_PERF_EN
    logic [31:0]  cyc_cnt, br_cnt;
`endif

    pc_sequencer #(.D(D), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .stall(stall), .halt(halt), .jump(jump), .jump_addr(jump_addr),
        .br_taken(br_taken), .br_sel(br_sel), .lut_sel(lut_sel),
        .lut_target(lut_target), .pc(pc), .busy(busy), .done(done),
`ifdef PC_SEQ_PERF_EN
        .cyc_cnt(cyc_cnt), .br_cnt(br_cnt),
`endif
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // model: 0 = idle, 1 = running, 2 = halted
    int           m_mode;
    logic [D-1:0] m_pc;
    int           m_exec;
    logic         m_to;
    longint       m_cyc, m_brc;

    task automatic model_step();
        if (reset) begin
            m_mode = 0; m_pc = '0; m_exec = 0; m_to = 1'b0; m_cyc = 0; m_brc = 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_pc = start_addr; m_exec = 0; m_to = 1'b0; m_cyc = 0; m_brc = 0;
            end
        end else begin
            m_cyc++;
            if (!stall) begin
                m_exec++;
                if (halt) m_mode = 2;
                else if (m_exec == TO) begin m_mode = 2; m_to = 1'b1; end
                else if (jump) begin m_pc = jump_addr; m_brc++; end
                else if (br_taken) begin
                    m_pc = D'((int'(m_pc) + int'(lut_target)) % (1 << D)); m_brc++;
                end else m_pc = D'((int'(m_pc) + 1) % (1 << D));
            end
        end
    endtask

    task automatic quiet();
        reset = 0; start = 0; stall = 0; halt = 0; jump = 0; br_taken = 0;
        start_addr = '0; jump_addr = '0; lut_target = '0; br_sel = '0;
    endtask

    task automatic tick();
        #1;
        chk("lut_sel", 32'(lut_sel), 32'(br_sel));
        @(posedge clk);
        model_step();
        #1;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("done", 32'(done), 32'(m_mode == 2));
        chk("timeout", 32'(timeout), 32'(m_to));
`ifdef PC_SEQ_PERF_EN
        chk("cyc_cnt", cyc_cnt, 32'(m_cyc));
        chk("br_cnt", br_cnt, 32'(m_brc));
`endif
        quiet();
    endtask

    task automatic do_start(input logic [D-1:0] a);
        start = 1; start_addr = a; tick();
    endtask

    task automatic do_halt();
        halt = 1; tick();
    endtask

    initial begin
        quiet();
        m_mode = 0; m_pc = '0; m_exec = 0; m_to = 0; m_cyc = 0; m_brc = 0;
        @(negedge clk);
        reset = 1; tick();
        reset = 1; tick();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // sequential run from 0x010
        do_start(12'h010);
        chk("start_pc", 32'(pc), 32'h010);
        chk("start_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 5; i++) tick();
        chk("seq_pc", 32'(pc), 32'h015);

        // negative relative branch
        do_halt();
        do_start(12'h020);
        br_taken = 1; br_sel = 3'd5; lut_target = 12'hFF8; tick();
        chk("br_neg", 32'(pc), 32'h018);

        // branch wraps below zero, then increment wraps past top
        do_halt();
        do_start(12'h001);
        br_taken = 1; br_sel = 3'd2; lut_target = 12'hFFE; tick();
        chk("br_wrap", 32'(pc), 32'hFFF);
        tick();
        chk("inc_wrap", 32'(pc), 32'h000);

        // jump beats branch; stall beats jump
        do_halt();
        do_start(12'h100);
        jump = 1; br_taken = 1; jump_addr = 12'h300; lut_target = 12'h004; tick();
        chk("jump_prio", 32'(pc), 32'h300);
        stall = 1; jump = 1; jump_addr = 12'h055; tick();
        chk("stall_jump", 32'(pc), 32'h300);

        // halt and restart from HALTED
        do_halt();
        do_start(12'h042);
        do_halt();
        chk("halt_pc", 32'(pc), 32'h042);
        chk("halt_done", 32'(done), 32'h1);
        tick();
        chk("halt_hold", 32'(pc), 32'h042);
        do_start(12'h000);
        chk("restart_done", 32'(done), 32'h0);
        chk("restart_busy", 32'(busy), 32'h1);

        // watchdog: two stalls do not count, 8th executed cycle halts
        stall = 1; tick();
        stall = 1; tick();
        for (int i = 0; i < 7; i++) tick();
        chk("wd_pre_busy", 32'(busy), 32'h1);
        chk("wd_pre_pc", 32'(pc), 32'h007);
        jump = 1; jump_addr = 12'h777; tick();
        chk("wd_done", 32'(done), 32'h1);
        chk("wd_timeout", 32'(timeout), 32'h1);
        chk("wd_pc", 32'(pc), 32'h007);
        tick();
        chk("wd_timeout_hold", 32'(timeout), 32'h1);

        // explicit halt on the watchdog cycle leaves timeout clear
        do_start(12'h200);
        for (int i = 0; i < 7; i++) tick();
        do_halt();
        chk("wd_halt_done", 32'(done), 32'h1);
        chk("wd_halt_to", 32'(timeout), 32'h0);

        // reset mid-run
        do_start(12'h120);
        for (int i = 0; i < 3; i++) tick();
        chk("pre_rst_pc", 32'(pc), 32'h123);
        reset = 1; jump = 1; jump_addr = 12'h0AA; tick();
        chk("mid_rst_pc", 32'(pc), 32'h000);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        start = 0; tick();
        chk("idle_pc", 32'(pc), 32'h000);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            start      = ($urandom_range(0, 9) == 0);
            start_addr = D'($urandom);
            stall      = ($urandom_range(0, 4) == 0);
            halt       = ($urandom_range(0, 24) == 0);
            jump       = ($urandom_range(0, 9) == 0);
            jump_addr  = D'($urandom);
            br_taken   = ($urandom_range(0, 3) == 0);
            br_sel     = 3'($urandom);
            lut_target = D'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
